// File: rtl/board_io_pkg.sv
// Shared register map, reset constants and seven-segment decode for board_io_ctrl.
package board_io_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned SEG_W  = 7;

  localparam logic [ADDR_W-1:0] ADDR_LED          = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_SW           = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_KEY_LEVEL    = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_KEY_EDGE     = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK     = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_HEX_MODE     = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_HEX_VALUE    = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_HEX_BLANK    = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_HEX_RAW_BASE = 4'd8;

  localparam logic [SEG_W-1:0] HEX_BLANK_PATTERN = 7'h7F;
  localparam logic             HEX_MODE_RESET    = 1'b1;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [SEG_W-1:0] hex7seg(input logic [3:0] nibble);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, stability counter, debounced level and a one-cycle press strobe.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             differ;
  logic             accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= ~key_n;
      sync_q    <= sync_meta;
    end
  end

  assign differ  = sync_q ^ level;
  // The cycle that would bring the count to DEBOUNCE_CYCLES flips the level instead.
  assign accept  = differ && (cnt_q == CNT_LAST);
  assign press_c = accept & ~level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      level <= 1'b0;
    end else begin
      if (!differ || accept) cnt_q <= '0;
      else                   cnt_q <= cnt_q + CNT_W'(1);
      if (accept) level <= ~level;
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// Bus-mapped controller for switches, keys, LEDs and seven-segment digits.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned N_SW            = 10,
  parameter int unsigned N_LED           = 10,
  parameter int unsigned N_KEY           = 4,
  parameter int unsigned N_HEX           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     irq,
  input  logic [N_SW-1:0]          SW,
  input  logic [N_KEY-1:0]         KEY,
  output logic [N_LED-1:0]         LEDR,
  output logic [SEG_W*N_HEX-1:0]   HEX
);

  localparam int unsigned VAL_W = 4 * N_HEX;

  logic [N_LED-1:0]        led_q;
  logic [N_SW-1:0]         sw_meta;
  logic [N_SW-1:0]         sw_sync;
  logic [N_KEY-1:0]        key_level;
  logic [N_KEY-1:0]        key_press_c;
  logic [N_KEY-1:0]        key_edge_q;
  logic [N_KEY-1:0]        mask_q;
  logic                    mode_q;
  logic [VAL_W-1:0]        value_q;
  logic [N_HEX-1:0]        blank_q;
  logic [SEG_W-1:0]        raw_q [N_HEX];

  logic                    raw_hit;
  logic [ADDR_W-1:0]       raw_idx;
  logic [N_KEY-1:0]        edge_clr;
  logic [N_KEY-1:0]        edge_d;
  logic [N_KEY-1:0]        mask_d;
  logic [DATA_W-1:0]       rd_d;
  logic [SEG_W*N_HEX-1:0]  hex_d;
  logic                    unused_wr_data;

  assign unused_wr_data = ^wr_data;
  assign LEDR           = led_q;

  for (genvar k = 0; k < N_KEY; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .key_n  (KEY[k]),
      .level  (key_level[k]),
      .press_c(key_press_c[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  assign raw_idx = addr - ADDR_HEX_RAW_BASE;
  assign raw_hit = (addr >= ADDR_HEX_RAW_BASE) && (raw_idx < ADDR_W'(N_HEX));

  // Plain R/W registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= '0;
      mask_q  <= '0;
      mode_q  <= HEX_MODE_RESET;
      value_q <= '0;
      blank_q <= '1;
      for (int i = 0; i < N_HEX; i++) raw_q[i] <= HEX_BLANK_PATTERN;
    end else if (wr_en) begin
      case (addr)
        ADDR_LED:       led_q   <= wr_data[N_LED-1:0];
        ADDR_IRQ_MASK:  mask_q  <= wr_data[N_KEY-1:0];
        ADDR_HEX_MODE:  mode_q  <= wr_data[0];
        ADDR_HEX_VALUE: value_q <= wr_data[VAL_W-1:0];
        ADDR_HEX_BLANK: blank_q <= wr_data[N_HEX-1:0];
        default: ;
      endcase
      for (int i = 0; i < N_HEX; i++) begin
        if (raw_hit && (raw_idx == ADDR_W'(i))) raw_q[i] <= wr_data[SEG_W-1:0];
      end
    end
  end

  // Edge capture: a press arriving with a W1C on the same bit survives.
  always_comb begin
    edge_clr = '0;
    if (wr_en && (addr == ADDR_KEY_EDGE)) edge_clr = wr_data[N_KEY-1:0];
    edge_d = (key_edge_q & ~edge_clr) | key_press_c;
    mask_d = (wr_en && (addr == ADDR_IRQ_MASK)) ? wr_data[N_KEY-1:0] : mask_q;
  end

  // irq is built from next-state values so it moves on the same edge as the edge bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_edge_q <= '0;
      irq        <= 1'b0;
    end else begin
      key_edge_q <= edge_d;
      irq        <= |(edge_d & mask_d);
    end
  end

  always_comb begin
    rd_d = '0;
    case (addr)
      ADDR_LED:       rd_d = DATA_W'(led_q);
      ADDR_SW:        rd_d = DATA_W'(sw_sync);
      ADDR_KEY_LEVEL: rd_d = DATA_W'(key_level);
      ADDR_KEY_EDGE:  rd_d = DATA_W'(key_edge_q);
      ADDR_IRQ_MASK:  rd_d = DATA_W'(mask_q);
      ADDR_HEX_MODE:  rd_d = DATA_W'(mode_q);
      ADDR_HEX_VALUE: rd_d = DATA_W'(value_q);
      ADDR_HEX_BLANK: rd_d = DATA_W'(blank_q);
      default: begin
        for (int i = 0; i < N_HEX; i++) begin
          if (raw_hit && (raw_idx == ADDR_W'(i))) rd_d = DATA_W'(raw_q[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= rd_d;
  end

  always_comb begin
    hex_d = '1;
    for (int i = 0; i < N_HEX; i++) begin
      if (blank_q[i])  hex_d[SEG_W*i +: SEG_W] = HEX_BLANK_PATTERN;
      else if (mode_q) hex_d[SEG_W*i +: SEG_W] = hex7seg(value_q[4*i +: 4]);
      else             hex_d[SEG_W*i +: SEG_W] = raw_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) HEX <= {N_HEX{HEX_BLANK_PATTERN}};
    else       HEX <= hex_d;
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed and randomized checks of board_io_ctrl against a cycle-level reference model.
module tb_board_io_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned NSW  = 10;
  localparam int unsigned NLED = 10;
  localparam int unsigned NKEY = 4;
  localparam int unsigned NHEX = 6;
  localparam int unsigned DEB  = 4;

  logic            clk     = 1'b0;
  logic            reset   = 1'b1;
  logic [3:0]      addr    = '0;
  logic            wr_en   = 1'b0;
  logic            rd_en   = 1'b0;
  logic [DW-1:0]   wr_data = '0;
  logic [NSW-1:0]  SW      = '0;
  logic [NKEY-1:0] KEY     = '1;
  logic [DW-1:0]   rd_data;
  logic            irq;
  logic [NLED-1:0] LEDR;
  logic [7*NHEX-1:0] HEX;

  int errors = 0;
  int checks = 0;

  board_io_ctrl #(
    .DATA_W(DW), .N_SW(NSW), .N_LED(NLED), .N_KEY(NKEY), .N_HEX(NHEX), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .irq(irq), .SW(SW), .KEY(KEY), .LEDR(LEDR), .HEX(HEX)
  );

  always #5 clk = ~clk;

  logic [6:0] seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model state.
  logic [NLED-1:0]   m_led;
  logic [NKEY-1:0]   m_mask, m_edge, m_level;
  logic              m_mode;
  logic [4*NHEX-1:0] m_value;
  logic [NHEX-1:0]   m_blank;
  logic [6:0]        m_raw [NHEX];
  logic [DW-1:0]     m_rd;
  logic              m_irq;
  logic [7*NHEX-1:0] m_hex;
  logic [NSW-1:0]    m_sw_prev1, m_sw_prev2;
  // Pressed history per key, index 0 = sample taken at the current edge.
  logic              m_samp [NKEY][DEB+2];

  function automatic logic [DW-1:0] model_read(input logic [3:0] a);
    int idx;
    idx = int'(a) - 8;
    case (a)
      4'd0: return DW'(m_led);
      4'd1: return DW'(m_sw_prev2);
      4'd2: return DW'(m_level);
      4'd3: return DW'(m_edge);
      4'd4: return DW'(m_mask);
      4'd5: return DW'(m_mode);
      4'd6: return DW'(m_value);
      4'd7: return DW'(m_blank);
      default: begin
        if (idx >= 0 && idx < int'(NHEX)) return DW'(m_raw[idx]);
        return '0;
      end
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [7*NHEX-1:0] hx;
    logic [NKEY-1:0]   press;
    logic [NKEY-1:0]   clr;
    logic              all_diff;
    int                idx;
    if (reset) begin
      m_led = '0; m_mask = '0; m_edge = '0; m_level = '0; m_mode = 1'b1;
      m_value = '0; m_blank = '1; m_rd = '0; m_irq = 1'b0; m_hex = '1;
      m_sw_prev1 = '0; m_sw_prev2 = '0;
      for (int i = 0; i < int'(NHEX); i++) m_raw[i] = 7'h7F;
      for (int k = 0; k < int'(NKEY); k++)
        for (int j = 0; j < int'(DEB) + 2; j++) m_samp[k][j] = 1'b0;
    end else begin
      for (int i = 0; i < int'(NHEX); i++)
        hx[7*i +: 7] = m_blank[i] ? 7'h7F : (m_mode ? seg[m_value[4*i +: 4]] : m_raw[i]);
      if (rd_en) m_rd = model_read(addr);
      m_sw_prev2 = m_sw_prev1;
      m_sw_prev1 = SW;
      press = '0;
      for (int k = 0; k < int'(NKEY); k++) begin
        for (int j = int'(DEB) + 1; j > 0; j--) m_samp[k][j] = m_samp[k][j-1];
        m_samp[k][0] = ~KEY[k];
        // Accept when the last DEB synchronised samples (2 edges old) all disagree with the level.
        all_diff = 1'b1;
        for (int j = 2; j < int'(DEB) + 2; j++)
          if (m_samp[k][j] == m_level[k]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[k] = ~m_level[k];
          press[k]   = m_level[k];
        end
      end
      clr = '0;
      if (wr_en) begin
        idx = int'(addr) - 8;
        case (addr)
          4'd0: m_led   = wr_data[NLED-1:0];
          4'd3: clr     = wr_data[NKEY-1:0];
          4'd4: m_mask  = wr_data[NKEY-1:0];
          4'd5: m_mode  = wr_data[0];
          4'd6: m_value = wr_data[4*NHEX-1:0];
          4'd7: m_blank = wr_data[NHEX-1:0];
          default: if (idx >= 0 && idx < int'(NHEX)) m_raw[idx] = wr_data[6:0];
        endcase
      end
      m_edge = (m_edge & ~clr) | press;
      m_irq  = |(m_edge & m_mask);
      m_hex  = hx;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [DW-1:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    addr = a; rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    checks++; if (LEDR !== '0) begin errors++; $display("FAIL reset_ledr got %h want 0", LEDR); end
    checks++; if (HEX !== 42'h3FF_FFFF_FFFF) begin errors++; $display("FAIL reset_hex got %h want 3ffffffffff", HEX); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd got %h want 0", rd_data); end
    rd(4'd5);
    checks++; if (rd_data !== 32'd1) begin errors++; $display("FAIL reset_mode got %h want 1", rd_data); end
    rd(4'd7);
    checks++; if (rd_data !== 32'h3F) begin errors++; $display("FAIL reset_blank got %h want 3f", rd_data); end
  endtask

  task automatic test_led();
    SW = 10'h155;
    wr(4'd0, 32'h2A5);
    checks++; if (LEDR !== 10'h2A5) begin errors++; $display("FAIL led_out got %h want 2a5", LEDR); end
    rd(4'd0);
    checks++; if (rd_data !== 32'h2A5) begin errors++; $display("FAIL led_read got %h want 2a5", rd_data); end
    wr(4'd1, 32'hFFF);
    rd(4'd1);
    checks++; if (rd_data !== 32'h155) begin errors++; $display("FAIL sw_ro got %h want 155", rd_data); end
  endtask

  task automatic test_hex();
    wr(4'd7, 32'h0);
    wr(4'd6, 32'h0012AF);
    checks++; if (HEX !== {6{7'b1000000}}) begin errors++; $display("FAIL hex_unblank got %h want %h", HEX, {6{7'b1000000}}); end
    cyc();
    checks++;
    if (HEX !== {7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}) begin
      errors++; $display("FAIL hex_decode got %h want %h", HEX,
        {7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});
    end
    wr(4'd5, 32'h0);
    wr(4'd8, 32'h55);
    cyc();
    checks++; if (HEX !== {{5{7'h7F}}, 7'h55}) begin errors++; $display("FAIL hex_raw got %h want %h", HEX, {{5{7'h7F}}, 7'h55}); end
  endtask

  task automatic test_key_debounce();
    wr(4'd4, 32'h2);
    KEY[1] = 1'b0;
    repeat (3) cyc();
    KEY[1] = 1'b1;
    repeat (8) cyc();
    rd(4'd2);
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL bounce_level got %h want 0", rd_data); end
    rd(4'd3);
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL bounce_edge got %h want 0", rd_data); end
    KEY[1] = 1'b0;
    repeat (5) cyc();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL press_early_irq got %b want 0", irq); end
    cyc();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL press_irq got %b want 1", irq); end
    rd(4'd2);
    checks++; if (rd_data !== 32'h2) begin errors++; $display("FAIL press_level got %h want 2", rd_data); end
    rd(4'd3);
    checks++; if (rd_data !== 32'h2) begin errors++; $display("FAIL press_edge got %h want 2", rd_data); end
    wr(4'd3, 32'h2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b want 0", irq); end
    rd(4'd3);
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL w1c_edge got %h want 0", rd_data); end
  endtask

  task automatic test_set_wins();
    KEY[0] = 1'b0;
    repeat (5) cyc();
    addr = 4'd3; wr_data = 32'h1; wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
    rd(4'd3);
    checks++; if (rd_data !== 32'h1) begin errors++; $display("FAIL set_wins got %h want 1", rd_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL set_wins_irq got %b want 0", irq); end
    KEY = '1;
    repeat (8) cyc();
    wr(4'd3, 32'hF);
    rd(4'd2);
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL release_level got %h want 0", rd_data); end
  endtask

  task automatic test_sw_and_reset();
    logic [DW-1:0] want;
    SW = '0;
    repeat (3) cyc();
    SW = 10'h100; addr = 4'd1; rd_en = 1'b1;
    cyc(); cyc();
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL sw_early got %h want 0", rd_data); end
    cyc();
    checks++; if (rd_data !== 32'h100) begin errors++; $display("FAIL sw_sync got %h want 100", rd_data); end
    rd_en = 1'b0;
    KEY[2] = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    checks++; if (LEDR !== '0 || irq !== 1'b0) begin errors++; $display("FAIL midreset_out got %h/%b want 0/0", LEDR, irq); end
    reset = 1'b0; addr = 4'd3; rd_en = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      cyc();
      want = (n == 7) ? 32'h4 : 32'h0;
      checks++; if (rd_data !== want) begin errors++; $display("FAIL postreset_edge cycle %0d got %h want %h", n, rd_data, want); end
    end
    rd_en = 1'b0;
    rd(4'd2);
    checks++; if (rd_data !== 32'h4) begin errors++; $display("FAIL postreset_level got %h want 4", rd_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < int'(NKEY); k++)
        if ($urandom_range(0, 5) == 0) KEY[k] = ~KEY[k];
      if ($urandom_range(0, 15) == 0) SW = NSW'($urandom);
      wr_en   = ($urandom_range(0, 2) == 0);
      rd_en   = ($urandom_range(0, 1) == 1);
      addr    = 4'($urandom);
      wr_data = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 4'd3;
      cyc();
      checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL rand_rd cycle %0d got %h want %h", n, rd_data, m_rd); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq cycle %0d got %b want %b", n, irq, m_irq); end
      checks++; if (LEDR !== m_led) begin errors++; $display("FAIL rand_led cycle %0d got %h want %h", n, LEDR, m_led); end
      checks++; if (HEX !== m_hex) begin errors++; $display("FAIL rand_hex cycle %0d got %h want %h", n, HEX, m_hex); end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_led();
    test_hex();
    test_key_debounce();
    test_set_wins();
    test_sw_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised, bus-mapped controller for the board's switches, keys, LEDs and seven-segment displays, used by MyComputer as its I/O peripheral. It replaces direct wiring of SW/KEY/LEDR/HEX with:
- synchronised switch reads;
- debounced, edge-captured keys with a maskable interrupt;
- a LED register;
- seven-segment outputs driven either from a hex value (decode mode) or from raw per-digit segment patterns.

## Interface
Parameters:
- DATA_W, 32, bus data width (≥ 4*N_HEX and ≥ N_SW, N_LED).
- N_SW, 10, switch count.
- N_LED, 10, LED count.
- N_KEY, 4, key count.
- N_HEX, 6, seven-segment digit count, 1..8.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a key change, ≥ 1.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  4  word address.
- wr_en  in  1  write strobe.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_data  out  DATA_W  registered read data.
- irq  out  1  interrupt, = |(edge & mask).
- SW  in  N_SW  raw asynchronous switches.
- KEY  in  N_KEY  raw asynchronous keys, active-low (0 = pressed).
- LEDR  out  N_LED  LED drive.
- HEX  out  7*N_HEX  digit i occupies HEX[7i+6:7i] = {g,f,e,d,c,b,a}, active-low.

## Operation
Register map (word address, access, reset value):
- 0 LED, R/W, 0. Drives LEDR directly.
- 1 SW, RO. 2-flop synchronised SW; synchronisers reset to 0.
- 2 KEY_LEVEL, RO, 0. Debounced level, 1 = pressed.
- 3 KEY_EDGE, R/W1C, 0. A bit sets when its debounced level goes 0→1. Writing 1 clears the bit. On a same-cycle set and clear, set wins.
- 4 IRQ_MASK, R/W, 0.
- 5 HEX_MODE, R/W, 1. Bit0 = 1 selects decode mode; 0 selects raw mode.
- 6 HEX_VALUE, R/W, 0. Nibble i is shown on digit i in decode mode.
- 7 HEX_BLANK, R/W, all ones. Bit i forces digit i to 7'h7F in either mode.
- 8+i (i < N_HEX) HEX_RAW[i], R/W, 7'h7F. Digit i's pattern in raw mode.

Access rules:
- Unmapped reads return 0; writes to RO or unmapped addresses are ignored.
- Unused upper data bits read 0.
- Digit encoding, active-low: 0=7'b1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Key debounce, per key:
- Raw KEY is inverted and passes through a 2-flop synchroniser (reset to released).
- A counter increments each cycle the synchronised value differs from the debounced level, and clears on any cycle where they match.
- When the counter reaches DEBOUNCE_CYCLES, the level flips and the counter clears.
- Release transitions are filtered identically but set no edge bit.

## Timing
- All outputs reset to: LEDR=0, HEX all 7'h7F, rd_data=0, irq=0.
- Write: sampled at edge k, register updated at k. LEDR changes at k. HEX is registered and changes at k+1.
- Read: rd_en/addr sampled at edge k, rd_data valid after k until the next read. rd_data holds its value when rd_en=0.
- Read and write to the same address in one cycle: the read returns the old value.
- Switch: a change seen at edge k is readable via register 1 from edge k+2.
- Key press: raw KEY low and stable from edge k. The synchronised value differs from k+2, and level and edge bit set at edge k+1+DEBOUNCE_CYCLES. irq follows the same cycle if masked in.
- Any bounce shorter than DEBOUNCE_CYCLES produces no level change.
- reset asserted mid-debounce: counters, levels, edges and synchronisers return to reset values immediately. No edge is reported for a key still held at reset release until it has been stably pressed for 2+DEBOUNCE_CYCLES cycles.

## Structure
- Package board_io_pkg holds:
  - register address localparams;
  - reset constants (HEX_BLANK_PATTERN = 7'h7F);
  - function hex7seg(nibble) → active-low 7-bit pattern.
- Sub-module key_debounce (synchroniser, counter, level, press pulse) is instantiated N_KEY times via generate.
- The top level holds the register file, read mux, HEX output register and irq.

## Test plan
- Reset with DEBOUNCE_CYCLES=4 → LEDR=0, HEX=42'h3FF_FFFF_FFFF, irq=0; read addr 5 → 1, addr 7 → 6'h3F.
- Write addr0 = 0x2A5 → LEDR=10'h2A5 at the same edge; read addr0 → 0x2A5; write addr1 = 0xFFF → SW read unchanged.
- Write addr7 = 0, addr6 = 0x0012AF → one edge later HEX0=0001110, HEX1=0001000, HEX2=0100100, HEX3=1111001, HEX4=HEX5=1000000. Then write addr5=0, addr8=7'h55 → HEX0=7'h55, others 7'h7F.
- Mask=0x2. KEY[1] low for 3 cycles then high → no level/edge change. KEY[1] held low → level and edge bit1 at edge k+5, irq=1. Write addr3=0x2 → edge=0, irq=0.
- Write 1 to KEY_EDGE bit0 on the same edge the KEY[0] press is accepted → bit0 reads 1.
- SW[8]=1 → read addr1 returns 0x100 from edge k+2. Assert reset for 1 cycle during a KEY[2] debounce → level 0, no edge. Keep KEY[2] held → press accepted 6 cycles after release of reset.
